// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int FERR_CNT_MAX  = 255;
  localparam int UART_RX_DEPTH = 16;

  // One receiver strobe: the byte plus its framing-error flag.
  typedef struct packed {
    uart_byte_t data;
    logic       ferr;
  } uart_rx_beat_t;

  function automatic logic [7:0] ferr_sat_inc(input logic [7:0] v);
    return (v == 8'(FERR_CNT_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = CW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + CW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + CW'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge gclk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer: framing-error filter, FWFT queue, overflow and error-count flags.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_RX_DEPTH,
  parameter bit DROP_ERR = 1'b1,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  uart_byte_t    in_data,
  input  logic          in_valid,
  input  logic          in_ferr,
  output uart_byte_t    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    ferr_cnt,
  input  logic          clr_flags
);

  uart_rx_beat_t beat;
  logic          empty, full;
  logic          good, pop, push, ferr_evt;
  logic          overflow_q, overflow_d;
  logic [7:0]    ferr_cnt_q, ferr_cnt_d;

  assign beat     = '{data: in_data, ferr: in_ferr};
  assign ferr_evt = in_valid & beat.ferr;
  assign good     = in_valid & ~(beat.ferr & DROP_ERR);
  assign pop      = out_valid & out_ready;
  assign push     = good & (~full | pop);

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(uart_byte_t)),
    .CW    (CW)
  ) u_fifo (
    .gclk    (gclk),
    .grst_n  (grst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (beat.data),
    .rdata_o (out_data),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  assign out_valid = ~empty;

  // A set/increment in the same cycle as clr_flags wins over the clear.
  always_comb begin
    overflow_d = overflow_q;
    ferr_cnt_d = ferr_cnt_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      ferr_cnt_d = '0;
    end
    if (good & full & ~pop) overflow_d = 1'b1;
    if (ferr_evt) ferr_cnt_d = clr_flags ? 8'd1 : ferr_sat_inc(ferr_cnt_q);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      overflow_q <= 1'b0;
      ferr_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign ferr_cnt = ferr_cnt_q;

endmodule
